// File: rtl/effects_pkg.sv
// ============================================================================
//  Module      : effects_pkg
//  Description : Shared widths and sequencer state type for the effects block.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package effects_pkg;

    localparam int SAMPLE_W = 13;
    localparam int OUT_W    = 16;
    localparam int GAIN_W   = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RAMP    = 2'd3
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/gain_slew.sv
// ============================================================================
//  Module      : gain_slew
//  Description : Gain target handshake and per-sample slew-limited gain value.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gain_slew
    import effects_pkg::*;
#(
    parameter int                GAIN_W    = effects_pkg::GAIN_W,
    parameter logic [GAIN_W-1:0] GAIN_INIT = GAIN_W'(256),
    parameter logic [GAIN_W-1:0] GAIN_STEP = GAIN_W'(8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ramp_en_i,
    input  logic              gain_req_i,
    input  logic [GAIN_W-1:0] gain_target_i,
    output logic              gain_ack_o,
    output logic [GAIN_W-1:0] gain_cur_o
);

    logic [GAIN_W-1:0] cur_q;
    logic [GAIN_W-1:0] cur_d;
    logic [GAIN_W-1:0] tgt_q;
    logic              ack_q;
    logic              accept;
    logic [GAIN_W-1:0] up_dist;
    logic [GAIN_W-1:0] dn_dist;

    // The ack of the previous cycle blocks acceptance, so a held req lands every other cycle.
    assign accept  = gain_req_i & ~ack_q;
    assign up_dist = tgt_q - cur_q;
    assign dn_dist = cur_q - tgt_q;

    always_comb begin
        cur_d = cur_q;
        if (tgt_q >= cur_q) begin
            if (up_dist <= GAIN_STEP) cur_d = tgt_q;
            else                      cur_d = cur_q + GAIN_STEP;
        end else begin
            if (dn_dist <= GAIN_STEP) cur_d = tgt_q;
            else                      cur_d = cur_q - GAIN_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= GAIN_INIT;
            tgt_q <= GAIN_INIT;
            ack_q <= 1'b0;
        end else begin
            ack_q <= accept;
            if (accept)    tgt_q <= gain_target_i;
            if (ramp_en_i) cur_q <= cur_d;
        end
    end

    assign gain_ack_o = ack_q;
    assign gain_cur_o = cur_q;

endmodule

`default_nettype wire

// File: rtl/effects_sequencer.sv
// ============================================================================
//  Module      : effects_sequencer
//  Description : Per-sample sequencer for the external effects pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module effects_sequencer #(
    parameter int                SAMPLE_W  = effects_pkg::SAMPLE_W,
    parameter int                OUT_W     = effects_pkg::OUT_W,
    parameter int                GAIN_W    = effects_pkg::GAIN_W,
    parameter logic [GAIN_W-1:0] GAIN_INIT = GAIN_W'(256),
    parameter logic [GAIN_W-1:0] GAIN_STEP = GAIN_W'(8)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                adc_strobe_i,
    input  logic [SAMPLE_W-1:0] adc_sample_i,
    input  logic                gain_req_i,
    input  logic [GAIN_W-1:0]   gain_target_i,
    output logic                gain_ack_o,
    output logic                pipe_valid_o,
    output logic [SAMPLE_W-1:0] pipe_sample_o,
    output logic [GAIN_W-1:0]   pipe_gain_o,
    input  logic [OUT_W-1:0]    pipe_out_i,
    output logic                dac_valid_o,
    output logic [OUT_W-1:0]    dac_sample_o,
    output logic                overrun_o,
    input  logic                overrun_clr_i
);

    import effects_pkg::*;

    seq_state_t          state_q;
    seq_state_t          state_d;
    logic [SAMPLE_W-1:0] pipe_sample_q;
    logic [OUT_W-1:0]    dac_sample_q;
    logic                dac_valid_q;
    logic                prime_cnt_q;
    logic                overrun_q;
    logic                ramp_en;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (adc_strobe_i) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RAMP;
            RAMP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ramp_en = (state_q == RAMP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pipe_sample_q <= '0;
            dac_sample_q  <= '0;
            dac_valid_q   <= 1'b0;
            prime_cnt_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dac_valid_q <= 1'b0;
            if (state_q == IDLE && adc_strobe_i) begin
                pipe_sample_q <= adc_sample_i;
            end
            // The pipe holds the previous sample's result; the first capture after reset is stale.
            if (state_q == CAPTURE) begin
                dac_sample_q <= pipe_out_i;
                if (prime_cnt_q) dac_valid_q <= 1'b1;
                else             prime_cnt_q <= 1'b1;
            end
            overrun_q <= (adc_strobe_i && state_q != IDLE) | (overrun_q & ~overrun_clr_i);
        end
    end

    gain_slew #(
        .GAIN_W    (GAIN_W),
        .GAIN_INIT (GAIN_INIT),
        .GAIN_STEP (GAIN_STEP)
    ) u_gain_slew (
        .clk           (clk),
        .rst           (rst),
        .ramp_en_i     (ramp_en),
        .gain_req_i    (gain_req_i),
        .gain_target_i (gain_target_i),
        .gain_ack_o    (gain_ack_o),
        .gain_cur_o    (pipe_gain_o)
    );

    assign pipe_valid_o  = (state_q == ISSUE);
    assign pipe_sample_o = pipe_sample_q;
    assign dac_valid_o   = dac_valid_q;
    assign dac_sample_o  = dac_sample_q;
    assign overrun_o     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_effects_sequencer.sv
// ============================================================================
//  Module      : tb_effects_sequencer
//  Description : Self-checking bench for effects_sequencer with a pipeline model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_effects_sequencer;

    localparam int MODE_NORMAL  = 0;
    localparam int MODE_OVERRUN = 1;
    localparam int MODE_OVR_CLR = 2;
    localparam int MODE_REQ_ISS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        adc_strobe = 1'b0;
    logic [12:0] adc_sample = '0;
    logic        gain_req = 1'b0;
    logic [10:0] gain_target = '0;
    logic        gain_ack;
    logic        pipe_valid;
    logic [12:0] pipe_sample;
    logic [10:0] pipe_gain;
    logic [15:0] pipe_out;
    logic        dac_valid;
    logic [15:0] dac_sample;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    int n_total = 0;
    int n_pass  = 0;
    int n_pv_seen = 0;
    int exp_pv    = 0;
    logic [15:0] sb[$];
    logic        primed = 1'b0;
    logic [12:0] prev_s = '0;
    logic [10:0] prev_g = '0;

    always #5 clk = ~clk;

    effects_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .adc_strobe_i  (adc_strobe),
        .adc_sample_i  (adc_sample),
        .gain_req_i    (gain_req),
        .gain_target_i (gain_target),
        .gain_ack_o    (gain_ack),
        .pipe_valid_o  (pipe_valid),
        .pipe_sample_o (pipe_sample),
        .pipe_gain_o   (pipe_gain),
        .pipe_out_i    (pipe_out),
        .dac_valid_o   (dac_valid),
        .dac_sample_o  (dac_sample),
        .overrun_o     (overrun),
        .overrun_clr_i (overrun_clr)
    );

    // Overdrive stand-in: scaled product, saturated to the output width.
    function automatic logic [15:0] od(input logic [12:0] s, input logic [10:0] g);
        logic signed [24:0] p;
        p = $signed(s) * $signed({1'b0, g});
        p = p >>> 4;
        if (p > 25'sd32767)       return 16'h7FFF;
        else if (p < -25'sd32768) return 16'h8000;
        else                      return p[15:0];
    endfunction

    // External pipeline: input FF -> overdrive -> output FF, advanced by pipe_valid.
    logic [12:0] in_s;
    logic [10:0] in_g;
    logic [15:0] out_ff;
    always @(posedge clk) begin
        if (rst) begin
            in_s   <= '0;
            in_g   <= '0;
            out_ff <= '0;
        end else if (pipe_valid) begin
            in_s   <= pipe_sample;
            in_g   <= pipe_gain;
            out_ff <= od(in_s, in_g);
        end
    end
    assign pipe_out = out_ff;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Scoreboard consumer: every dac_valid must match the oldest expected sample.
    always @(negedge clk) begin
        if (pipe_valid) n_pv_seen++;
        if (dac_valid) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL dac_valid_unexpected: got pulse with %0d expected none at %0t",
                         dac_sample, $time);
            end else begin
                chk("dac_sample", 32'(dac_sample), 32'(sb.pop_front()));
            end
        end
    end

    task automatic do_sample(input logic [12:0] s, input logic [10:0] gi,
                             input logic [10:0] ga, input int mode);
        adc_sample = s;
        adc_strobe = 1'b1;
        @(negedge clk);
        adc_strobe = 1'b0;
        adc_sample = 13'h0AA;
        chk("pipe_valid_issue", 32'(pipe_valid), 32'd1);
        chk("pipe_sample", 32'(pipe_sample), 32'(s));
        chk("issue_gain", 32'(pipe_gain), 32'(gi));
        exp_pv++;
        if (primed) sb.push_back(od(prev_s, prev_g));
        prev_s = s;
        prev_g = gi;
        primed = 1'b1;
        if (mode == MODE_REQ_ISS) begin
            gain_req    = 1'b1;
            gain_target = 11'd280;
        end
        @(negedge clk);
        gain_req = 1'b0;
        chk("pipe_valid_capture", 32'(pipe_valid), 32'd0);
        if (mode == MODE_REQ_ISS) begin
            chk("ack_after_issue_req", 32'(gain_ack), 32'd1);
            chk("capture_gain_hold", 32'(pipe_gain), 32'(gi));
        end
        if (mode == MODE_OVERRUN || mode == MODE_OVR_CLR) begin
            adc_strobe  = 1'b1;
            adc_sample  = 13'd999;
            overrun_clr = (mode == MODE_OVR_CLR);
        end
        @(negedge clk);
        adc_strobe  = 1'b0;
        overrun_clr = 1'b0;
        chk("ramp_gain_hold", 32'(pipe_gain), 32'(gi));
        if (mode == MODE_OVERRUN || mode == MODE_OVR_CLR) begin
            chk("overrun_set", 32'(overrun), 32'd1);
            chk("dropped_sample", 32'(pipe_sample), 32'(s));
        end
        @(negedge clk);
        chk("after_gain", 32'(pipe_gain), 32'(ga));
        repeat (4) @(negedge clk);
    endtask

    task automatic gain_request(input logic [10:0] t);
        gain_req    = 1'b1;
        gain_target = t;
        @(negedge clk);
        gain_req = 1'b0;
        chk("gain_ack", 32'(gain_ack), 32'd1);
        @(negedge clk);
        chk("gain_ack_pulse", 32'(gain_ack), 32'd0);
    endtask

    typedef struct {
        logic [12:0] s;
        logic [10:0] gi;
        logic [10:0] ga;
        int          mode;
    } vec_t;

    vec_t ramp_tbl[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ramp_tbl[0] = '{13'd10,    11'd256, 11'd264, MODE_NORMAL};
        ramp_tbl[1] = '{13'd4000,  11'd264, 11'd272, MODE_NORMAL};
        ramp_tbl[2] = '{13'h1E0C,  11'd272, 11'd280, MODE_NORMAL};
        ramp_tbl[3] = '{13'd40,    11'd280, 11'd288, MODE_NORMAL};
        ramp_tbl[4] = '{13'd50,    11'd288, 11'd296, MODE_NORMAL};
        ramp_tbl[5] = '{13'd60,    11'd296, 11'd296, MODE_NORMAL};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_pipe_valid", 32'(pipe_valid), 32'd0);
        chk("rst_dac_valid", 32'(dac_valid), 32'd0);
        chk("rst_pipe_sample", 32'(pipe_sample), 32'd0);
        chk("rst_dac_sample", 32'(dac_sample), 32'd0);
        chk("rst_pipe_gain", 32'(pipe_gain), 32'd256);
        chk("rst_gain_ack", 32'(gain_ack), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Priming: the first sample yields no dac_valid
        do_sample(13'd100, 11'd256, 11'd256, MODE_NORMAL);
        do_sample(13'd200, 11'd256, 11'd256, MODE_NORMAL);
        do_sample(13'd300, 11'd256, 11'd256, MODE_NORMAL);

        // Held req: accepted, then re-accepted two cycles later
        gain_req    = 1'b1;
        gain_target = 11'd296;
        @(negedge clk);
        chk("held_ack0", 32'(gain_ack), 32'd1);
        @(negedge clk);
        chk("held_ack1", 32'(gain_ack), 32'd0);
        @(negedge clk);
        chk("held_ack2", 32'(gain_ack), 32'd1);
        gain_req = 1'b0;
        @(negedge clk);
        chk("held_ack3", 32'(gain_ack), 32'd0);
        for (int i = 0; i < 6; i++)
            do_sample(ramp_tbl[i].s, ramp_tbl[i].gi, ramp_tbl[i].ga, ramp_tbl[i].mode);

        // Slew down to 8, then a sub-step move to 3 must land exactly without wrap
        gain_request(11'd8);
        for (int k = 0; k < 36; k++)
            do_sample(13'(k * 7 + 1), 11'(296 - 8 * k), 11'(288 - 8 * k), MODE_NORMAL);
        gain_request(11'd3);
        do_sample(13'd77, 11'd8, 11'd3, MODE_NORMAL);
        do_sample(13'd88, 11'd3, 11'd3, MODE_NORMAL);

        // Overrun: dropped strobe, set-beats-clear, explicit clear, normal recovery
        do_sample(13'd500, 11'd3, 11'd3, MODE_OVERRUN);
        do_sample(13'd600, 11'd3, 11'd3, MODE_OVR_CLR);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("overrun_cleared", 32'(overrun), 32'd0);
        do_sample(13'd700, 11'd3, 11'd3, MODE_NORMAL);

        // Reset during CAPTURE: in-flight sample lost, pipe re-primes
        adc_sample = 13'd777;
        adc_strobe = 1'b1;
        @(negedge clk);
        adc_strobe = 1'b0;
        exp_pv++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        primed = 1'b0;
        chk("midrst_pipe_gain", 32'(pipe_gain), 32'd256);
        chk("midrst_dac_valid", 32'(dac_valid), 32'd0);
        chk("midrst_pipe_valid", 32'(pipe_valid), 32'd0);
        chk("midrst_pipe_sample", 32'(pipe_sample), 32'd0);
        @(negedge clk);
        chk("midrst_dac_valid2", 32'(dac_valid), 32'd0);
        repeat (3) @(negedge clk);
        do_sample(13'd1000, 11'd256, 11'd256, MODE_NORMAL);
        do_sample(13'd1100, 11'd256, 11'd256, MODE_NORMAL);

        // Gain request during ISSUE only moves gain in that sample's RAMP
        do_sample(13'd1200, 11'd256, 11'd264, MODE_REQ_ISS);
        do_sample(13'd1300, 11'd264, 11'd272, MODE_NORMAL);
        do_sample(13'd1400, 11'd272, 11'd280, MODE_NORMAL);
        do_sample(13'd1500, 11'd280, 11'd280, MODE_NORMAL);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("pipe_valid_count", 32'(n_pv_seen), 32'(exp_pv));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
